// File: rtl/seq_multiplier_if.sv
// Handshake/bus bundle for seq_multiplier.
// Master drives start/operands/mode; slave returns busy, done and product halves.
interface seq_multiplier_if #(
  parameter int DATA_W = 32
);
  logic              start_i;
  logic [DATA_W-1:0] src1_i;
  logic [DATA_W-1:0] src2_i;
  logic              signed_i;
  logic              busy_o;
  logic              done_o;
  logic [DATA_W-1:0] result_lo_o;
  logic [DATA_W-1:0] result_hi_o;

  modport master (
    output start_i, src1_i, src2_i, signed_i,
    input  busy_o, done_o, result_lo_o, result_hi_o
  );

  modport slave (
    input  start_i, src1_i, src2_i, signed_i,
    output busy_o, done_o, result_lo_o, result_hi_o
  );
endinterface

// File: rtl/seq_multiplier.sv
// Shift-add sequential multiplier: one multiplier bit per cycle, LSB first.
// Ports: clk_i, rst_i (sync, active-high), bus (seq_multiplier_if.slave:
// start_i, src1_i, src2_i, signed_i -> busy_o, done_o, result_lo_o, result_hi_o).
// Define SEQ_MUL_SIGNED_EN to honour signed_i; otherwise all multiplies are unsigned.
module seq_multiplier #(
  parameter int DATA_W = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  seq_multiplier_if.slave bus
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mq;
  logic [DATA_W-1:0] acc;
  logic [CNT_W-1:0]  cnt;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] res_lo;
  logic [DATA_W-1:0] res_hi;

  logic [DATA_W:0]     sum;
  logic [2*DATA_W-1:0] prod;
  logic [2*DATA_W-1:0] fin;
  logic [DATA_W-1:0]   op1;
  logic [DATA_W-1:0]   op2;

  // acc holds the upper half; mq shifts out multiplier bits and
  // fills with product low bits from the top.
  always_comb begin
    sum = {1'b0, acc} + (mq[0] ? {1'b0, mcand} : '0);
  end

  assign prod = {sum, mq[DATA_W-1:1]};

`ifdef SEQ_MUL_SIGNED_EN
  logic neg;
  logic neg_nxt;
  logic sgn1;
  logic sgn2;

  assign sgn1 = bus.signed_i & bus.src1_i[DATA_W-1];
  assign sgn2 = bus.signed_i & bus.src2_i[DATA_W-1];
  // Most negative value negates to itself, which is its correct unsigned magnitude.
  assign op1 = sgn1 ? (~bus.src1_i + 1'b1) : bus.src1_i;
  assign op2 = sgn2 ? (~bus.src2_i + 1'b1) : bus.src2_i;
  assign neg_nxt = sgn1 ^ sgn2;
  assign fin = neg ? (~prod + 1'b1) : prod;
`else
  logic unused_signed;

  assign unused_signed = bus.signed_i;
  assign op1 = bus.src1_i;
  assign op2 = bus.src2_i;
  assign fin = prod;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      mcand  <= '0;
      mq     <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      res_lo <= '0;
      res_hi <= '0;
`ifdef SEQ_MUL_SIGNED_EN
      neg    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (bus.start_i) begin
            mcand <= op1;
            mq    <= op2;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
`ifdef SEQ_MUL_SIGNED_EN
            neg   <= neg_nxt;
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc <= sum[DATA_W:1];
          mq  <= prod[DATA_W-1:0];
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            busy   <= 1'b0;
            done   <= 1'b1;
            res_lo <= fin[DATA_W-1:0];
            res_hi <= fin[2*DATA_W-1:DATA_W];
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy_o      = busy;
  assign bus.done_o      = done;
  assign bus.result_lo_o = res_lo;
  assign bus.result_hi_o = res_hi;

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameter: DATA_W, 32, operand width in bits; product width is 2*DATA_W.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset, synchronous and active-high.
REQ-004 start_i  input  1  request pulse; sampled each rising edge.
REQ-005 src1_i  input  DATA_W  multiplicand (register-file RS read data).
REQ-006 src2_i  input  DATA_W  multiplier (register-file RT read data).
REQ-007 signed_i  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-008 busy_o  output  1  high while a multiply is in progress.
REQ-009 done_o  output  1  one-cycle pulse: result valid.
REQ-010 result_lo_o  output  DATA_W  product bits [DATA_W-1:0] (to the writeback select).
REQ-011 result_hi_o  output  DATA_W  product bits [2*DATA_W-1:DATA_W].

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 IDLE with start_i=1 SHALL do all of the following at that edge: latch src1_i, src2_i and signed_i; clear the accumulator; clear the bit counter; go to RUN.
REQ-014 RUN SHALL process exactly one multiplier bit per cycle using shift-add, LSB first.
REQ-015 RUN SHALL last exactly DATA_W cycles; the counter counts 0..DATA_W-1 and then goes to DONE.
REQ-016 DONE SHALL last one cycle with done_o=1, then go to IDLE.
REQ-017 Latency: start_i accepted at edge T -> done_o high in cycle T+DATA_W+1 (cycle 33 for DATA_W=32).
REQ-018 busy_o SHALL be 1 in RUN only; done_o SHALL be 1 in DONE only.
REQ-019 start_i in RUN SHALL be ignored; the latched operands SHALL NOT change.
REQ-020 start_i in DONE SHALL be accepted as in IDLE, giving back-to-back operation (DONE -> RUN).
REQ-021 result_hi_o/result_lo_o SHALL update only when entering DONE and SHALL hold until the next accepted start's DONE.
REQ-022 Signed mode: multiply the operand magnitudes; negate the full 2*DATA_W product when the operand signs differ.
REQ-023 Signed edge case: the most negative operand SHALL use its DATA_W-bit unsigned magnitude (no overflow); 0x80000000 * 0xFFFFFFFF signed = hi 0x00000000, lo 0x80000000.
REQ-024 Unsigned product SHALL be exact over 2*DATA_W bits, with no truncation or wrap.
REQ-025 A zero operand SHALL still take the full DATA_W-cycle latency, with result 0.

Reset
REQ-026 rst_i=1 at a rising edge SHALL force IDLE and clear the counter, accumulator and latched operands.
REQ-027 After that edge: busy_o=0, done_o=0, result_lo_o=0, result_hi_o=0.
REQ-028 Reset during RUN or DONE SHALL abort the operation; no done_o pulse follows.
REQ-029 start_i SHALL be ignored in any cycle where rst_i=1.

Configuration
REQ-030 Macro SEQ_MUL_SIGNED_EN defined: signed_i SHALL be honoured per REQ-022/REQ-023.
REQ-031 Macro SEQ_MUL_SIGNED_EN undefined: signed_i SHALL be ignored, all operations SHALL be unsigned, and no sign/negate logic SHALL be synthesised; ports are unchanged.

Verification
REQ-032 Reset, then start with src1=3, src2=5, signed=0 -> busy_o cycles 1..32, done_o in cycle 33, lo=0x0000000F, hi=0x00000000.
REQ-033 Unsigned 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; same operands with signed=1 (macro defined) -> hi=0x00000000, lo=0x00000001.
REQ-034 Signed -3*7 (0xFFFFFFFD, 0x00000007), macro defined -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; macro undefined -> hi=0x00000006, lo=0xFFFFFFEB.
REQ-035 Start 2*2; pulse start_i with 9*9 in cycle 10 -> ignored, result lo=4.
REQ-036 Start 2*2, then start_i held in the DONE cycle with 6*7 -> done_o again 33 cycles later with lo=42.
REQ-037 Reset in cycle 10 of RUN -> next cycle busy_o=0, result=0; done_o never asserts; a fresh start completes normally.
